vtdl_fifo: RTL
==============

VTDL_FIFO -- requirements
Module: vtdl_fifo

Interface
REQ-001 SHALL have parameter WID, default 8, data width in bits.
REQ-002 SHALL have parameter DEP, default 16, storage depth in entries; power of two, >= 4.
REQ-003 SHALL have parameter AFULL, default DEP-2, almost-full threshold in entries.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-006 SHALL have port wr  input  1  write request.
REQ-007 SHALL have port din  input  WID  write data.
REQ-008 SHALL have port rd  input  1  read request; pops the word currently on dout.
REQ-009 SHALL have port dout  output  WID  oldest stored word (first-word-fall-through).
REQ-010 SHALL have port empty  output  1  no words stored.
REQ-011 SHALL have port full  output  1  DEP words stored.
REQ-012 SHALL have port afull  output  1  count >= AFULL.
REQ-013 SHALL have port cnt  output  $clog2(DEP)+1  words stored, 0..DEP.
REQ-014 SHALL have port ovf  output  1  sticky overflow flag.
REQ-015 SHALL have port unf  output  1  sticky underflow flag.

Function
REQ-016 Write accepted = wr & (!full | rd_acc); accepted write shifts din into storage position 0 and moves every stored word up one position in the same cycle.
REQ-017 Read accepted (rd_acc) = rd & !empty; dout SHALL be the storage word at position cnt-1, combinational from registered state.
REQ-018 cnt SHALL update next edge: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-019 Simultaneous accepted read and write SHALL shift storage and hold cnt; the new oldest word then sits at cnt-1.
REQ-020 Write latency: word written at edge N SHALL appear on dout after edge N when FIFO was empty (empty deasserts same edge).
REQ-021 empty, full, afull SHALL be registered and consistent with cnt every cycle (empty = cnt==0, full = cnt==DEP).
REQ-022 dout SHALL be forced to zero while empty.
REQ-023 Write while full without simultaneous read SHALL be dropped, storage and cnt unchanged, ovf set.
REQ-024 Read while empty SHALL be ignored, cnt unchanged, unf set; simultaneous wr on empty still accepted.
REQ-025 Read while full with write SHALL accept both; full stays asserted.
REQ-026 ovf and unf SHALL remain set until rst.
REQ-027 cnt SHALL never wrap past DEP or below 0.

Reset
REQ-028 On rst high at an edge: cnt=0, empty=1, full=0, afull=0 (AFULL>0), ovf=0, unf=0, dout=0.
REQ-029 Storage contents SHALL NOT be reset; they are unobservable after reset because empty masks dout.
REQ-030 rst SHALL override concurrent wr/rd; a mid-operation reset discards all stored words.

Structure
REQ-031 Storage SHALL be one instance of the existing vtdl delay line (WID, DEP), ce = write accepted, a = cnt-1 truncated to $clog2(DEP) bits, d = din.
REQ-032 Control (count, flags) SHALL be local to vtdl_fifo; no shared package is required; the count width localparam SHALL be derived in-module.

Verification
REQ-033 Reset, write 0x11,0x22,0x33 on consecutive cycles -> cnt=3, dout=0x11; read 3 cycles -> dout 0x22, 0x33, then empty=1, dout=0.
REQ-034 Fill 16 writes (DEP=16) -> full=1, afull asserted at cnt=14; 17th write only -> dropped, ovf=1, cnt=16.
REQ-035 Full, assert rd & wr with din=0xAA for 16 cycles -> cnt stays 16, dout walks original order, 0xAA then appears in order.
REQ-036 Empty, rd=1 alone -> unf=1, cnt=0; rd & wr with din=0x5C -> write accepted, cnt=1, dout=0x5C.
REQ-037 cnt=5, rst pulsed one cycle with wr=1 -> cnt=0, empty=1, ovf=unf=0, dout=0.
REQ-038 Random wr/rd, 10k cycles vs scoreboard queue -> dout matches queue head every non-empty cycle, flags match model.

Source files
------------

// File: rtl/vtdl_fifo_pkg.sv
// vtdl_fifo_pkg -- shared types for the vtdl-based FIFO.
//   flags_t : registered status bits of the FIFO, kept together so the
//             reset value and next-state can be built as one unit.
package vtdl_fifo_pkg;

    typedef struct packed {
        logic empty;
        logic full;
        logic afull;
        logic ovf;
        logic unf;
    } flags_t;

endpackage

// File: rtl/vtdl.sv
// vtdl -- variable-tap delay line.
//   clk : clock, rising edge
//   ce  : shift enable; d enters position 0, every word moves up one
//   a   : tap address, selects the word at position a
//   d   : input word
//   q   : word at position a (combinational from storage)
// Storage has no reset; the FIFO masks stale contents with its count.
module vtdl #(
    parameter int WID = 8,
    parameter int DEP = 16
) (
    input  logic                   clk,
    input  logic                   ce,
    input  logic [$clog2(DEP)-1:0] a,
    input  logic [WID-1:0]         d,
    output logic [WID-1:0]         q
);

    logic [DEP-1:0][WID-1:0] sr_q;
    logic [DEP-1:0][WID-1:0] sr_d;

    for (genvar i = 0; i < DEP; i++) begin : g_stage
        if (i == 0) begin : g_head
            assign sr_d[i] = ce ? d : sr_q[i];
        end else begin : g_body
            assign sr_d[i] = ce ? sr_q[i-1] : sr_q[i];
        end
    end

    always_ff @(posedge clk) begin
        sr_q <= sr_d;
    end

    assign q = sr_q[a];

endmodule

// File: rtl/vtdl_fifo.sv
// vtdl_fifo -- first-word-fall-through FIFO built on a shifting delay line.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, overrides wr/rd
//   wr    : write request, din : write data
//   rd    : read request, pops the word currently on dout
//   dout  : oldest word (zero while empty)
//   empty / full / afull : registered status, consistent with cnt
//   cnt   : words stored, 0..DEP
//   ovf   : sticky, a write was dropped because the FIFO was full
//   unf   : sticky, a read was issued while empty
// New words always enter position 0 of the delay line and age upward, so
// the oldest word lives at position cnt-1.
module vtdl_fifo
    import vtdl_fifo_pkg::*;
#(
    parameter int WID   = 8,
    parameter int DEP   = 16,
    parameter int AFULL = DEP - 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  logic [WID-1:0]       din,
    input  logic                 rd,
    output logic [WID-1:0]       dout,
    output logic                 empty,
    output logic                 full,
    output logic                 afull,
    output logic [$clog2(DEP):0] cnt,
    output logic                 ovf,
    output logic                 unf
);

    localparam int AW = $clog2(DEP);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEP_C   = CW'(DEP);
    localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

    logic [CW-1:0]  cnt_q, cnt_d;
    flags_t         flags_q, flags_d;
    logic           wr_acc, rd_acc;
    logic [AW-1:0]  tap_a;
    logic [WID-1:0] tap_q;

    always_comb begin
        rd_acc = rd & ~flags_q.empty;
        // A read frees the top slot in the same cycle, so full does not
        // block a write that is paired with an accepted read.
        wr_acc = wr & (~flags_q.full | rd_acc);

        cnt_d = cnt_q;
        case ({wr_acc, rd_acc})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase

        flags_d       = flags_q;
        flags_d.empty = (cnt_d == '0);
        flags_d.full  = (cnt_d == DEP_C);
        flags_d.afull = (cnt_d >= AFULL_C);
        flags_d.ovf   = flags_q.ovf | (wr & ~wr_acc);
        flags_d.unf   = flags_q.unf | (rd & flags_q.empty);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            flags_q.empty <= 1'b1;
            flags_q.full  <= 1'b0;
            flags_q.afull <= (AFULL_C == '0);
            flags_q.ovf   <= 1'b0;
            flags_q.unf   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            flags_q <= flags_d;
        end
    end

    // cnt-1 wraps to all-ones when empty; harmless since dout is masked.
    assign tap_a = AW'(cnt_q - CW'(1));

    vtdl #(
        .WID (WID),
        .DEP (DEP)
    ) u_dline (
        .clk (clk),
        .ce  (wr_acc),
        .a   (tap_a),
        .d   (din),
        .q   (tap_q)
    );

    assign dout  = flags_q.empty ? '0 : tap_q;
    assign cnt   = cnt_q;
    assign empty = flags_q.empty;
    assign full  = flags_q.full;
    assign afull = flags_q.afull;
    assign ovf   = flags_q.ovf;
    assign unf   = flags_q.unf;

endmodule
